// File: rtl/fb_write_queue.sv
// Write-side queue and single-port arbiter for the 512x512x1 SPRAM framebuffer.
// Dithered words are queued, then drained into the SPRAM on cycles the scanout reader leaves idle.
module fb_write_queue #(
  parameter int DEPTH     = 4,
  parameter int ADDR_BITS = 14,
  parameter int DATA_BITS = 16
) (
  input  logic                       clk_16mhz,
  input  logic                       reset,
  input  logic [DATA_BITS-1:0]       mono_bits,
  input  logic [11:0]                mono_xaddr,
  input  logic [11:0]                mono_yaddr,
  input  logic                       mono_bits_ready,
  input  logic                       rd_req,
  input  logic [ADDR_BITS-1:0]       rd_addr,
  output logic [ADDR_BITS-1:0]       fb_addr,
  output logic                       fb_wen,
  output logic [DATA_BITS-1:0]       fb_wr_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  output logic [7:0]                 drop_count
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = ADDR_BITS + DATA_BITS;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  logic [ENTRY_W-1:0] fifo_mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_reg;
  logic [PTR_W-1:0]   rd_ptr_reg;
  logic [CNT_W-1:0]   count_reg;

  logic               in_window;
  logic               accept;
  logic               pop;
  logic               push;
  logic               drop;
  logic [ENTRY_W-1:0] new_entry;
  logic [ENTRY_W-1:0] head_entry;
  logic [3:0]         unused_x_low;

  // Word-aligned x: the low nibble never carries address information.
  assign unused_x_low = mono_xaddr[3:0];

  assign in_window  = (mono_xaddr[11:9] == 3'd0) && (mono_yaddr[11:9] == 3'd0);
  assign accept     = mono_bits_ready && in_window;
  // Pop looks only at the registered count, so a freshly pushed word cannot bypass.
  assign pop        = !rd_req && (count_reg != '0);
  assign push       = accept && ((count_reg != FULL_COUNT) || pop);
  assign drop       = accept && !push;
  assign new_entry  = {ADDR_BITS'({mono_yaddr[8:0], mono_xaddr[8:4]}), mono_bits};
  assign head_entry = fifo_mem[rd_ptr_reg];
  assign level      = count_reg;

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk_16mhz) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= new_entry;
    end
  end

  always_ff @(posedge clk_16mhz or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Scanout owns the port whenever it asks; writes fill the remaining cycles.
  always_ff @(posedge clk_16mhz or posedge reset) begin
    if (reset) begin
      fb_addr    <= '0;
      fb_wen     <= 1'b0;
      fb_wr_data <= '0;
    end else if (rd_req) begin
      fb_addr <= rd_addr;
      fb_wen  <= 1'b0;
    end else if (pop) begin
      fb_addr    <= head_entry[ENTRY_W-1:DATA_BITS];
      fb_wr_data <= head_entry[DATA_BITS-1:0];
      fb_wen     <= 1'b1;
    end else begin
      fb_wen <= 1'b0;
    end
  end

  always_ff @(posedge clk_16mhz or posedge reset) begin
    if (reset) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      overflow <= drop;
      if (drop && (drop_count != 8'hFF)) begin
        drop_count <= drop_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_fb_write_queue.sv
// Directed bench for fb_write_queue: vector table for the steady-state behaviour,
// hand-written sequences for reset mid-operation and drop-counter saturation.
module tb_fb_write_queue;

  logic        clk_16mhz = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] mono_bits = '0;
  logic [11:0] mono_xaddr = '0;
  logic [11:0] mono_yaddr = '0;
  logic        mono_bits_ready = 1'b0;
  logic        rd_req = 1'b0;
  logic [13:0] rd_addr = '0;
  logic [13:0] fb_addr;
  logic        fb_wen;
  logic [15:0] fb_wr_data;
  logic [2:0]  level;
  logic        overflow;
  logic [7:0]  drop_count;

  int n_cmp = 0;
  int n_bad = 0;

  fb_write_queue #(.DEPTH(4), .ADDR_BITS(14), .DATA_BITS(16)) dut (
    .clk_16mhz(clk_16mhz), .reset(reset),
    .mono_bits(mono_bits), .mono_xaddr(mono_xaddr), .mono_yaddr(mono_yaddr),
    .mono_bits_ready(mono_bits_ready), .rd_req(rd_req), .rd_addr(rd_addr),
    .fb_addr(fb_addr), .fb_wen(fb_wen), .fb_wr_data(fb_wr_data),
    .level(level), .overflow(overflow), .drop_count(drop_count)
  );

  always #5 clk_16mhz = ~clk_16mhz;

  typedef struct {
    logic        stb;
    logic [11:0] x;
    logic [11:0] y;
    logic [15:0] bits;
    logic        rd;
    logic [13:0] ra;
    logic        wen;
    logic [13:0] addr;
    logic [15:0] data;
    logic [2:0]  lvl;
    logic        ovf;
    logic [7:0]  drop;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic stb, input logic [11:0] x, input logic [11:0] y,
                     input logic [15:0] bits, input logic rd, input logic [13:0] ra,
                     input logic wen, input logic [13:0] addr, input logic [15:0] data,
                     input logic [2:0] lvl, input logic ovf, input logic [7:0] drop);
    vec_t v;
    v.stb = stb; v.x = x; v.y = y; v.bits = bits; v.rd = rd; v.ra = ra;
    v.wen = wen; v.addr = addr; v.data = data; v.lvl = lvl; v.ovf = ovf; v.drop = drop;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic stb, input logic [11:0] x, input logic [11:0] y,
                       input logic [15:0] bits, input logic rd, input logic [13:0] ra);
    mono_bits_ready = stb; mono_xaddr = x; mono_yaddr = y; mono_bits = bits;
    rd_req = rd; rd_addr = ra;
  endtask

  task automatic step();
    @(posedge clk_16mhz);
    #1;
  endtask

  initial begin
    // Table: inputs during one cycle, outputs expected just after the following edge.
    //   stb  x       y       bits      rd  ra         wen addr      data      lvl ovf drop
    add(1, 12'h020, 12'h005, 16'hA5A5, 0, 14'h0000,  0, 14'h0000, 16'h0000, 1, 0, 0);
    add(0, 12'h000, 12'h000, 16'h0000, 0, 14'h0000,  1, 14'h00A2, 16'hA5A5, 0, 0, 0);
    add(0, 12'h000, 12'h000, 16'h0000, 0, 14'h0000,  0, 14'h00A2, 16'hA5A5, 0, 0, 0);
    add(1, 12'h1F0, 12'h1FF, 16'h0F0F, 0, 14'h0000,  0, 14'h00A2, 16'hA5A5, 1, 0, 0);
    add(0, 12'h000, 12'h000, 16'h0000, 1, 14'h1234,  0, 14'h1234, 16'hA5A5, 1, 0, 0);
    add(0, 12'h000, 12'h000, 16'h0000, 1, 14'h1234,  0, 14'h1234, 16'hA5A5, 1, 0, 0);
    add(0, 12'h000, 12'h000, 16'h0000, 1, 14'h1234,  0, 14'h1234, 16'hA5A5, 1, 0, 0);
    add(0, 12'h000, 12'h000, 16'h0000, 0, 14'h0000,  1, 14'h3FFF, 16'h0F0F, 0, 0, 0);
    add(1, 12'h000, 12'h001, 16'h0001, 1, 14'h0100,  0, 14'h0100, 16'h0F0F, 1, 0, 0);
    add(1, 12'h010, 12'h001, 16'h0002, 1, 14'h0100,  0, 14'h0100, 16'h0F0F, 2, 0, 0);
    add(1, 12'h020, 12'h001, 16'h0003, 1, 14'h0100,  0, 14'h0100, 16'h0F0F, 3, 0, 0);
    add(1, 12'h030, 12'h001, 16'h0004, 1, 14'h0100,  0, 14'h0100, 16'h0F0F, 4, 0, 0);
    add(1, 12'h040, 12'h001, 16'h0005, 1, 14'h0100,  0, 14'h0100, 16'h0F0F, 4, 1, 1);
    add(0, 12'h000, 12'h000, 16'h0000, 1, 14'h0100,  0, 14'h0100, 16'h0F0F, 4, 0, 1);
    add(1, 12'h050, 12'h001, 16'h0006, 0, 14'h0000,  1, 14'h0020, 16'h0001, 4, 0, 1);
    add(0, 12'h000, 12'h000, 16'h0000, 0, 14'h0000,  1, 14'h0021, 16'h0002, 3, 0, 1);
    add(0, 12'h000, 12'h000, 16'h0000, 0, 14'h0000,  1, 14'h0022, 16'h0003, 2, 0, 1);
    add(0, 12'h000, 12'h000, 16'h0000, 0, 14'h0000,  1, 14'h0023, 16'h0004, 1, 0, 1);
    add(0, 12'h000, 12'h000, 16'h0000, 0, 14'h0000,  1, 14'h0025, 16'h0006, 0, 0, 1);
    add(0, 12'h000, 12'h000, 16'h0000, 0, 14'h0000,  0, 14'h0025, 16'h0006, 0, 0, 1);
    add(1, 12'h200, 12'h000, 16'hFFFF, 0, 14'h0000,  0, 14'h0025, 16'h0006, 0, 0, 1);
    add(1, 12'h000, 12'h200, 16'hFFFF, 0, 14'h0000,  0, 14'h0025, 16'h0006, 0, 0, 1);
    add(0, 12'h000, 12'h000, 16'h0000, 0, 14'h0000,  0, 14'h0025, 16'h0006, 0, 0, 1);

    // Reset values.
    step();
    step();
    chk("rst_wen", 32'(fb_wen), 32'h0);
    chk("rst_addr", 32'(fb_addr), 32'h0);
    chk("rst_data", 32'(fb_wr_data), 32'h0);
    chk("rst_level", 32'(level), 32'h0);
    chk("rst_ovf", 32'(overflow), 32'h0);
    chk("rst_drop", 32'(drop_count), 32'h0);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].stb, vecs[i].x, vecs[i].y, vecs[i].bits, vecs[i].rd, vecs[i].ra);
      step();
      $display("vec %0d: wen=%0d addr=0x%0h data=0x%0h level=%0d ovf=%0d drop=%0d",
               i, fb_wen, fb_addr, fb_wr_data, level, overflow, drop_count);
      chk($sformatf("v%0d_wen", i), 32'(fb_wen), 32'(vecs[i].wen));
      chk($sformatf("v%0d_addr", i), 32'(fb_addr), 32'(vecs[i].addr));
      chk($sformatf("v%0d_data", i), 32'(fb_wr_data), 32'(vecs[i].data));
      chk($sformatf("v%0d_level", i), 32'(level), 32'(vecs[i].lvl));
      chk($sformatf("v%0d_ovf", i), 32'(overflow), 32'(vecs[i].ovf));
      chk($sformatf("v%0d_drop", i), 32'(drop_count), 32'(vecs[i].drop));
    end

    // Reset mid-operation: fill four while reading, pop one, then reset with a write on the port.
    for (int k = 0; k < 4; k++) begin
      drive(1, 12'(12'h060 + 16 * k), 12'h002, 16'(16'h0100 + k), 1, 14'h0200);
      step();
    end
    drive(0, 12'h000, 12'h000, 16'h0000, 0, 14'h0000);
    step();
    chk("mid_pre_wen", 32'(fb_wen), 32'h1);
    chk("mid_pre_level", 32'(level), 32'h3);
    reset = 1'b1;
    #1;
    chk("mid_rst_wen", 32'(fb_wen), 32'h0);
    chk("mid_rst_level", 32'(level), 32'h0);
    chk("mid_rst_drop", 32'(drop_count), 32'h0);
    step();
    chk("mid_held_wen", 32'(fb_wen), 32'h0);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      $display("post-reset idle %0d: wen=%0d level=%0d", k, fb_wen, level);
      chk($sformatf("post_rst_wen%0d", k), 32'(fb_wen), 32'h0);
      chk($sformatf("post_rst_level%0d", k), 32'(level), 32'h0);
    end
    drive(1, 12'h000, 12'h000, 16'h5555, 0, 14'h0000);
    step();
    drive(0, 12'h000, 12'h000, 16'h0000, 0, 14'h0000);
    step();
    chk("post_rst_write_wen", 32'(fb_wen), 32'h1);
    chk("post_rst_write_addr", 32'(fb_addr), 32'h0);
    chk("post_rst_write_data", 32'(fb_wr_data), 32'h5555);
    step();
    chk("post_rst_write_once", 32'(fb_wen), 32'h0);

    // Drop-counter saturation: fill, then 300 drops with the port held by scanout.
    for (int k = 0; k < 304; k++) begin
      drive(1, 12'h000, 12'h003, 16'(k), 1, 14'h0000);
      step();
      if (k == 257) begin
        chk("sat_drop_254", 32'(drop_count), 32'd254);
      end
    end
    $display("saturation: level=%0d ovf=%0d drop=%0d", level, overflow, drop_count);
    chk("sat_level", 32'(level), 32'h4);
    chk("sat_ovf", 32'(overflow), 32'h1);
    chk("sat_drop", 32'(drop_count), 32'd255);
    drive(0, 12'h000, 12'h000, 16'h0000, 1, 14'h0000);
    step();
    chk("sat_ovf_clear", 32'(overflow), 32'h0);
    chk("sat_drop_hold", 32'(drop_count), 32'd255);
    drive(0, 12'h000, 12'h000, 16'h0000, 0, 14'h0000);
    step();
    chk("sat_first_write_data", 32'(fb_wr_data), 32'h0000);
    step();
    chk("sat_second_write_data", 32'(fb_wr_data), 32'h0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
